// File: rtl/dfilter_evt_ctrl.sv
// dfilter_evt_ctrl: register front-end and event controller for a bank of
// CH digital input filters sharing one refclk divider.
//   clk, rst_n              : clock, synchronous active-low reset
//   addr/we/wdata/re        : register write/read port (word address 0..7)
//   rdata/rvalid            : read data, one cycle after re (rdata 0 otherwise)
//   pol, flt_rise_st,
//   flt_fall_st, ref_st     : registered configuration to the filters/divider
//   data_flt                : live filter levels (LEVEL register)
//   act_edge/inact_edge     : per-channel edge pulses from the filters
//   irq                     : registered level interrupt, |(STATUS & IE)
module dfilter_evt_ctrl #(
  parameter int unsigned CH   = 4,
  parameter int unsigned BW   = 8,
  parameter int unsigned HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata,
  output logic          rvalid,
  output logic [CH-1:0] pol,
  output logic [BW-1:0] flt_rise_st,
  output logic [BW-1:0] flt_fall_st,
  output logic [2:0]    ref_st,
  input  logic [CH-1:0] data_flt,
  input  logic [CH-1:0] act_edge,
  input  logic [CH-1:0] inact_edge,
  output logic          irq
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned PW = $clog2(2 * CH + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);

  typedef enum logic [1:0] {S_DISABLED, S_HOLD, S_ARMED} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          en_q, en_d;
  logic [2:0]    ref_q, ref_d;
  logic [CH-1:0] pol_q, pol_d;
  logic [BW-1:0] rise_q, rise_d;
  logic [BW-1:0] fall_q, fall_d;
  logic [CH-1:0] ie_act_q, ie_act_d;
  logic [CH-1:0] ie_inact_q, ie_inact_d;
  logic [CH-1:0] st_act_q, st_act_d;
  logic [CH-1:0] st_inact_q, st_inact_d;
  logic [15:0]   evt_q, evt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          irq_q, irq_d;

  logic          wr_ctrl, wr_pol, wr_rise, wr_fall, wr_ie, wr_stat, wr_evt, cfg_wr;
  logic          armed;
  logic [CH-1:0] acc_act, acc_inact;
  logic [PW-1:0] n_evt;
  logic [16:0]   evt_sum;
  logic [31:0]   rd_word;
  logic          unused_wdata;

  assign wr_ctrl = we && (addr == 3'd0);
  assign wr_pol  = we && (addr == 3'd1);
  assign wr_rise = we && (addr == 3'd2);
  assign wr_fall = we && (addr == 3'd3);
  assign wr_ie   = we && (addr == 3'd4);
  assign wr_stat = we && (addr == 3'd5);
  assign wr_evt  = we && (addr == 3'd7);
  assign cfg_wr  = we && !addr[2];
  assign unused_wdata = ^wdata;

  // Mode FSM: any config write while enabled restarts the masking window
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      S_HOLD: begin
        if (hcnt_q == '0) state_d = S_ARMED;
        else              hcnt_d  = hcnt_q - CW'(1);
      end
      default: ;
    endcase
    if (wr_ctrl && !wdata[0]) begin
      state_d = S_DISABLED;
    end else if (cfg_wr && (wr_ctrl || en_q)) begin
      state_d = S_HOLD;
      hcnt_d  = HOLD_LOAD;
    end
  end

  // Edge pulses only count while armed
  assign armed     = (state_q == S_ARMED);
  assign acc_act   = armed ? act_edge   : '0;
  assign acc_inact = armed ? inact_edge : '0;

  always_comb begin
    n_evt = '0;
    for (int i = 0; i < CH; i++) begin
      n_evt = n_evt + PW'(acc_act[i]) + PW'(acc_inact[i]);
    end
  end

  // Clear-write zeroes the base so the same cycle's events are still counted
  assign evt_sum = 17'(wr_evt ? 16'h0000 : evt_q) + 17'(n_evt);

  // Register file next-state; new sets win over a same-cycle W1C
  always_comb begin
    en_d       = wr_ctrl ? wdata[0]          : en_q;
    ref_d      = wr_ctrl ? wdata[10:8]       : ref_q;
    pol_d      = wr_pol  ? wdata[CH-1:0]     : pol_q;
    rise_d     = wr_rise ? wdata[BW-1:0]     : rise_q;
    fall_d     = wr_fall ? wdata[BW-1:0]     : fall_q;
    ie_act_d   = wr_ie   ? wdata[CH-1:0]     : ie_act_q;
    ie_inact_d = wr_ie   ? wdata[16 +: CH]   : ie_inact_q;
    st_act_d   = (st_act_q   & ~(wr_stat ? wdata[CH-1:0]   : '0)) | acc_act;
    st_inact_d = (st_inact_q & ~(wr_stat ? wdata[16 +: CH] : '0)) | acc_inact;
    evt_d      = evt_sum[16] ? 16'hFFFF : evt_sum[15:0];
    irq_d      = |{st_act_q & ie_act_q, st_inact_q & ie_inact_q};
  end

  // Read mux sees pre-write register values
  always_comb begin
    rd_word = '0;
    case (addr)
      3'd0: begin
        rd_word[0]    = en_q;
        rd_word[10:8] = ref_q;
      end
      3'd1: rd_word[CH-1:0]   = pol_q;
      3'd2: rd_word[BW-1:0]   = rise_q;
      3'd3: rd_word[BW-1:0]   = fall_q;
      3'd4: begin
        rd_word[CH-1:0]   = ie_act_q;
        rd_word[16 +: CH] = ie_inact_q;
      end
      3'd5: begin
        rd_word[CH-1:0]   = st_act_q;
        rd_word[16 +: CH] = st_inact_q;
      end
      3'd6: rd_word[CH-1:0]   = data_flt;
      default: rd_word[15:0]  = evt_q;
    endcase
    rdata_d  = re ? rd_word : '0;
    rvalid_d = re;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_DISABLED;
      hcnt_q     <= '0;
      en_q       <= 1'b0;
      ref_q      <= 3'h2;
      pol_q      <= '1;
      rise_q     <= BW'(8'h08);
      fall_q     <= BW'(8'h08);
      ie_act_q   <= '0;
      ie_inact_q <= '0;
      st_act_q   <= '0;
      st_inact_q <= '0;
      evt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      en_q       <= en_d;
      ref_q      <= ref_d;
      pol_q      <= pol_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ie_act_q   <= ie_act_d;
      ie_inact_q <= ie_inact_d;
      st_act_q   <= st_act_d;
      st_inact_q <= st_inact_d;
      evt_q      <= evt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;
  assign pol         = pol_q;
  assign flt_rise_st = rise_q;
  assign flt_fall_st = fall_q;
  assign ref_st      = ref_q;
  assign irq         = irq_q;

endmodule
